// File: rtl/rb_writeback_pkg.sv
// Shared types and constants for the RB writeback stage: writeback-select
// encoding, load funct3 codes and default datapath sizes.
package rb_writeback_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int AW_DEF    = 5;
  localparam int CNT_W_DEF = 64;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/rb_writeback_if.sv
// Bundle of the M->RB pipeline fields, the decode read ports, the writeback
// bus towards the hazard unit and the retired-instruction count.
// master: producer side (pipeline / bench); slave: rb_writeback.
interface rb_writeback_if
  import rb_writeback_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int AW    = AW_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             valid_RB;
  logic             rd_wen_RB;
  logic [1:0]       PMAItoReg_RB;
  logic [XLEN-1:0]  instr_RB;
  logic [XLEN-1:0]  imm_RB;
  logic [XLEN-1:0]  mem_rdata_RB;
  logic [XLEN-1:0]  alu_result_RB;
  logic [XLEN-1:0]  PC_RB;
  logic [AW-1:0]    rd_waddr_RB;
  logic [AW-1:0]    rs1_raddr_D;
  logic [AW-1:0]    rs2_raddr_D;
  logic [XLEN-1:0]  rs1_rdata_D;
  logic [XLEN-1:0]  rs2_rdata_D;
  logic             wb_wen;
  logic [AW-1:0]    wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic [CNT_W-1:0] instret;

  modport master (
    output valid_RB, rd_wen_RB, PMAItoReg_RB, instr_RB, imm_RB, mem_rdata_RB,
           alu_result_RB, PC_RB, rd_waddr_RB, rs1_raddr_D, rs2_raddr_D,
    input  rs1_rdata_D, rs2_rdata_D, wb_wen, wb_addr, wb_data, instret
  );

  modport slave (
    input  valid_RB, rd_wen_RB, PMAItoReg_RB, instr_RB, imm_RB, mem_rdata_RB,
           alu_result_RB, PC_RB, rd_waddr_RB, rs1_raddr_D, rs2_raddr_D,
    output rs1_rdata_D, rs2_rdata_D, wb_wen, wb_addr, wb_data, instret
  );

endinterface

// File: rtl/rb_writeback_load_align.sv
// Load alignment: picks the byte/half lane addressed by the low address bits
// and sign- or zero-extends it according to funct3. Words (and unknown
// funct3 codes) pass through unchanged. Purely combinational.
module rb_writeback_load_align
  import rb_writeback_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane extraction and extension; halfword lane ignores off[0].
  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = word[{off[1], 4'b0000} +: 16];
    data   = word;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, lane_b};
      F3_LH:   data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/rb_writeback.sv
// Final writeback stage of the RV32I core: writeback-value select, load
// alignment, the integer register file with two combinational read ports,
// and the retired-instruction counter.
// Build option: define RB_BYPASS_EN to forward the in-flight writeback value
// onto a matching read port in the same cycle; otherwise reads return the
// pre-write array contents and decode must stall on an RB->D match.
module rb_writeback
  import rb_writeback_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int AW    = AW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  rb_writeback_if.slave  bus
);

  localparam int NREG = 2**AW;

  logic [XLEN-1:0]  regfile_reg [NREG];
  logic [CNT_W-1:0] instret_reg;
  logic [CNT_W-1:0] instret_next;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  wb_data_sel;
  logic             wb_wen_sel;
  logic [AW-1:0]    raddr [2];
  logic [XLEN-1:0]  rdata [2];

  // Only funct3 of the instruction word matters here.
  logic unused_instr;
  assign unused_instr = ^{bus.instr_RB[XLEN-1:15], bus.instr_RB[11:0]};

  rb_writeback_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3 (bus.instr_RB[14:12]),
    .off    (bus.alu_result_RB[1:0]),
    .word   (bus.mem_rdata_RB),
    .data   (load_data)
  );

  // Writeback select and write-enable qualification (x0 never written).
  always_comb begin
    wb_wen_sel = bus.valid_RB & bus.rd_wen_RB & (bus.rd_waddr_RB != '0);
    case (wb_sel_e'(bus.PMAItoReg_RB))
      WB_ALU:  wb_data_sel = bus.alu_result_RB;
      WB_MEM:  wb_data_sel = load_data;
      WB_PC4:  wb_data_sel = bus.PC_RB + XLEN'(4);
      WB_IMM:  wb_data_sel = bus.imm_RB;
      default: wb_data_sel = bus.alu_result_RB;
    endcase
  end

  assign bus.wb_wen  = wb_wen_sel;
  assign bus.wb_addr = bus.rd_waddr_RB;
  assign bus.wb_data = wb_data_sel;

  // Register file: async clear of every entry, write from the RB stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regfile_reg[i] <= '0;
    end else if (wb_wen_sel) begin
      regfile_reg[bus.rd_waddr_RB] <= wb_data_sel;
    end
  end

  assign raddr[0] = bus.rs1_raddr_D;
  assign raddr[1] = bus.rs2_raddr_D;

  // Read ports: address 0 is hardwired to zero; optional same-cycle forward.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rport
    always_comb begin
      rdata[gi] = regfile_reg[raddr[gi]];
`ifdef RB_BYPASS_EN
      if (wb_wen_sel && (raddr[gi] == bus.rd_waddr_RB)) rdata[gi] = wb_data_sel;
`endif
      if (raddr[gi] == '0) rdata[gi] = '0;
    end
  end

  assign bus.rs1_rdata_D = rdata[0];
  assign bus.rs2_rdata_D = rdata[1];

  // Retire count: one per valid RB slot, free-running wrap.
  always_comb begin
    instret_next = instret_reg;
    if (bus.valid_RB) instret_next = instret_reg + CNT_W'(1);
  end

  // Counter register with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_reg <= '0;
    else        instret_reg <= instret_next;
  end

  assign bus.instret = instret_reg;

endmodule

// File: tb/tb_rb_writeback.sv
// Self-checking bench for rb_writeback: directed cases followed by random
// traffic against a behavioural register-file / counter model. A second
// instance with a 3-bit counter exercises counter wrap-around.
module tb_rb_writeback;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef RB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rb_writeback_if #(.XLEN(32), .AW(5), .CNT_W(64)) ifc ();
  rb_writeback_if #(.XLEN(32), .AW(5), .CNT_W(3))  sm ();

  rb_writeback #(.XLEN(32), .AW(5), .CNT_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  rb_writeback #(.XLEN(32), .AW(5), .CNT_W(3)) dut_sm (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sm.slave)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] m_rf [32];
  logic [63:0] m_instret;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected load value from the raw word, written with plain arithmetic.
  function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_wbdata();
    case (ifc.PMAItoReg_RB)
      2'd0:    return ifc.alu_result_RB;
      2'd1:    return m_load(ifc.instr_RB[14:12], int'(ifc.alu_result_RB % 4), ifc.mem_rdata_RB);
      2'd2:    return ifc.PC_RB + 32'd4;
      default: return ifc.imm_RB;
    endcase
  endfunction

  function automatic bit m_wen();
    return ifc.valid_RB && ifc.rd_wen_RB && (ifc.rd_waddr_RB != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (BYP && m_wen() && a == ifc.rd_waddr_RB) return m_wbdata();
    return m_rf[a];
  endfunction

  task automatic drive(input bit v, input bit wen, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] imm, input logic [31:0] mem, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2);
    ifc.valid_RB      = v;
    ifc.rd_wen_RB     = wen;
    ifc.PMAItoReg_RB  = sel;
    ifc.instr_RB      = {17'h0, f3, 12'h003};
    ifc.imm_RB        = imm;
    ifc.mem_rdata_RB  = mem;
    ifc.alu_result_RB = alu;
    ifc.PC_RB         = pc;
    ifc.rd_waddr_RB   = rd;
    ifc.rs1_raddr_D   = r1;
    ifc.rs2_raddr_D   = r2;
  endtask

  // Called just after a negedge with inputs driven: check, clock, update model.
  task automatic step(input string tag);
    bit          w;
    logic [31:0] d;
    #1;
    w = m_wen();
    d = m_wbdata();
    chk({tag, "_wen"},   64'(ifc.wb_wen), 64'(w));
    chk({tag, "_waddr"}, 64'(ifc.wb_addr), 64'(ifc.rd_waddr_RB));
    chk({tag, "_wdata"}, 64'(ifc.wb_data), 64'(d));
    chk({tag, "_rs1"},   64'(ifc.rs1_rdata_D), 64'(m_read(ifc.rs1_raddr_D)));
    chk({tag, "_rs2"},   64'(ifc.rs2_rdata_D), 64'(m_read(ifc.rs2_raddr_D)));
    chk({tag, "_instret"}, ifc.instret, m_instret);
    @(posedge clk);
    if (w) m_rf[ifc.rd_waddr_RB] = d;
    if (ifc.valid_RB) m_instret = m_instret + 64'd1;
    @(negedge clk);
    $display("txn %s v=%0b wen=%0b sel=%0d rd=%0d wdata=0x%08h", tag, ifc.valid_RB, ifc.rd_wen_RB,
             ifc.PMAItoReg_RB, ifc.rd_waddr_RB, d);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_instret = 64'd0;
  endtask

  // Short async reset pulse between clock edges.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    drive(0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
    sm.valid_RB = 0; sm.rd_wen_RB = 0; sm.PMAItoReg_RB = 0; sm.instr_RB = 0;
    sm.imm_RB = 0; sm.mem_rdata_RB = 0; sm.alu_result_RB = 0; sm.PC_RB = 0;
    sm.rd_waddr_RB = 0; sm.rs1_raddr_D = 0; sm.rs2_raddr_D = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step("rst_idle");

    // 1: write x5, then async reset clears it before any clock edge.
    drive(1, 1, 2'd3, 3'd0, 32'h1234, 0, 0, 0, 5'd5, 5'd5, 5'd0);
    step("t1_wr_x5");
    drive(0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 5'd0, 5'd5, 5'd0);
    #1;
    chk("t1_x5_before", 64'(ifc.rs1_rdata_D), 64'h1234);
    rst_n = 1'b0;
    #1;
    chk("t1_x5_async", 64'(ifc.rs1_rdata_D), 64'h0);
    chk("t1_instret_async", ifc.instret, 64'h0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    // 2: load alignment on 0x80FF_7F01.
    drive(0, 1, 2'd1, 3'b000, 0, 32'h80FF_7F01, 32'h3, 0, 5'd1, 5'd0, 5'd0); #1;
    chk("t2_lb3", 64'(ifc.wb_data), 64'hFFFF_FF80);
    drive(0, 1, 2'd1, 3'b100, 0, 32'h80FF_7F01, 32'h3, 0, 5'd1, 5'd0, 5'd0); #1;
    chk("t2_lbu3", 64'(ifc.wb_data), 64'h0000_0080);
    drive(0, 1, 2'd1, 3'b001, 0, 32'h80FF_7F01, 32'h2, 0, 5'd1, 5'd0, 5'd0); #1;
    chk("t2_lh2", 64'(ifc.wb_data), 64'hFFFF_80FF);
    drive(0, 1, 2'd1, 3'b101, 0, 32'h80FF_7F01, 32'h0, 0, 5'd1, 5'd0, 5'd0); #1;
    chk("t2_lhu0", 64'(ifc.wb_data), 64'h0000_7F01);
    drive(0, 1, 2'd1, 3'b010, 0, 32'h80FF_7F01, 32'h1, 0, 5'd1, 5'd0, 5'd0); #1;
    chk("t2_lw", 64'(ifc.wb_data), 64'h80FF_7F01);
    @(negedge clk);

    // 3: writes to x0 are dropped, x0 reads zero.
    drive(1, 1, 2'd0, 3'd0, 0, 0, 32'hDEAD_BEEF, 0, 5'd0, 5'd0, 5'd0); #1;
    chk("t3_wen_x0", 64'(ifc.wb_wen), 64'h0);
    step("t3_x0");
    drive(0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0); #1;
    chk("t3_rd_x0", 64'(ifc.rs1_rdata_D), 64'h0);
    @(negedge clk);

    // 4: PC+4 wraps, immediate select.
    drive(0, 0, 2'd2, 3'd0, 0, 0, 0, 32'hFFFF_FFFC, 5'd3, 5'd0, 5'd0); #1;
    chk("t4_pc4", 64'(ifc.wb_data), 64'h0);
    drive(0, 0, 2'd3, 3'd0, 32'h0000_1000, 0, 0, 0, 5'd3, 5'd0, 5'd0); #1;
    chk("t4_imm", 64'(ifc.wb_data), 64'h1000);
    @(negedge clk);

    // 5: write x7 while decode reads it on rs2.
    drive(1, 1, 2'd0, 3'd0, 0, 0, 32'hA5A5_A5A5, 0, 5'd7, 5'd7, 5'd7); #1;
    chk("t5_rs2_same", 64'(ifc.rs2_rdata_D), BYP ? 64'hA5A5_A5A5 : 64'h0);
    step("t5_wr_x7");
    drive(0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 5'd0, 5'd7, 5'd7); #1;
    chk("t5_rs1_next", 64'(ifc.rs1_rdata_D), 64'hA5A5_A5A5);
    chk("t5_rs2_next", 64'(ifc.rs2_rdata_D), 64'hA5A5_A5A5);
    @(negedge clk);

    // 6: instret counts valid slots only, then wraps on the narrow instance.
    pulse_reset();
    @(negedge clk);
    drive(1, 1, 2'd0, 3'd0, 0, 0, 32'h11, 0, 5'd9, 5'd0, 5'd0); step("t6_c1");
    drive(1, 0, 2'd0, 3'd0, 0, 0, 32'h22, 0, 5'd9, 5'd0, 5'd0); step("t6_c2");
    drive(1, 1, 2'd0, 3'd0, 0, 0, 32'h33, 0, 5'd9, 5'd9, 5'd0); step("t6_c3");
    drive(0, 1, 2'd0, 3'd0, 0, 0, 32'h44, 0, 5'd9, 5'd9, 5'd0); step("t6_b1");
    drive(0, 1, 2'd0, 3'd0, 0, 0, 32'h55, 0, 5'd9, 5'd9, 5'd0); #1;
    chk("t6_instret3", ifc.instret, 64'd3);
    chk("t6_x9_bubble", 64'(ifc.rs1_rdata_D), 64'h33);
    @(negedge clk);
    drive(0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    sm.valid_RB = 1'b1;
    repeat (7) @(negedge clk);
    chk("t6_sm_max", 64'(sm.instret), 64'd7);
    @(negedge clk);
    chk("t6_sm_wrap", 64'(sm.instret), 64'd0);
    sm.valid_RB = 1'b0;
    m_instret = m_instret + 64'd0;
    @(negedge clk);

    // Random traffic; narrow address range makes read/write collisions common.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] rd, r1, r2;
      rd = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom, $urandom, rd, r1, r2);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
